// File: rtl/nes_bus_pkg.sv
// Shared types and constants for the NES CPU-side bus initiator.
package nes_bus_pkg;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

  localparam int NES_ADDR_W = 16;
  localparam int NES_DATA_W = 8;

  // Each M2 phase needs at least two clks so address setup and data hold fit.
  function automatic bit phase_lens_legal(input int low_clks, input int high_clks);
    return (low_clks >= 2) && (high_clks >= 2);
  endfunction

endpackage

// File: rtl/nes_irq_sync.sv
// Generic N-stage level synchroniser for an asynchronous input.
module nes_irq_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic synced
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain[0] <= level;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign synced = chain[STAGES-1];

endmodule

// File: rtl/nes_cpu_bus_initiator.sv
// Console-side 2A03-style bus initiator: free-running M2, one host request per bus cycle.
module nes_cpu_bus_initiator
  import nes_bus_pkg::*;
#(
  parameter int          M2_LOW_CLKS     = 3,
  parameter int          M2_HIGH_CLKS    = 3,
  parameter logic [15:0] IDLE_ADDR       = 16'h0000,
  parameter int          IRQ_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw_out,
  output logic [14:0] cpu_addr_out,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in,
  input  logic        irq,
  output logic        irq_active,
  output logic [31:0] m2_cycle_count
);

  if (!phase_lens_legal(M2_LOW_CLKS, M2_HIGH_CLKS)) begin : g_bad_phase_len
    $error("M2_LOW_CLKS and M2_HIGH_CLKS must both be at least 2");
  end

  localparam int MAX_CLKS = (M2_LOW_CLKS > M2_HIGH_CLKS) ? M2_LOW_CLKS : M2_HIGH_CLKS;
  localparam int CNT_W    = $clog2(MAX_CLKS);
  localparam logic [CNT_W-1:0] LAST_LOW  = CNT_W'(M2_LOW_CLKS - 1);
  localparam logic [CNT_W-1:0] LAST_HIGH = CNT_W'(M2_HIGH_CLKS - 1);

  phase_t           phase, phase_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             boundary;
  logic             accept;
  logic             m2_nxt;
  logic             addr15;
  logic             host_op;
  logic             irq_synced;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= PH_LOW;
      cnt   <= '0;
    end else begin
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = cnt + 1'b1;
    case (phase)
      PH_LOW: begin
        if (cnt == LAST_LOW) begin
          phase_nxt = PH_HIGH;
          cnt_nxt   = '0;
        end
      end
      PH_HIGH: begin
        if (cnt == LAST_HIGH) begin
          phase_nxt = PH_LOW;
          cnt_nxt   = '0;
        end
      end
      default: begin
        phase_nxt = PH_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    boundary  = (phase == PH_HIGH) && (cnt == LAST_HIGH);
    accept    = boundary && req_valid && !reset;
    req_ready = accept;
    m2_nxt    = (phase_nxt == PH_HIGH);
  end

  // Bus-facing registers all move on the same edge as the phase state, so
  // m2 and romsel switch together and the address is set up at LOW entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      m2             <= 1'b0;
      romsel         <= 1'b1;
      cpu_rw_out     <= 1'b1;
      cpu_addr_out   <= '0;
      cpu_data_out   <= '0;
      cpu_data_oe    <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      m2_cycle_count <= '0;
      addr15         <= 1'b0;
      host_op        <= 1'b0;
    end else begin
      m2        <= m2_nxt;
      romsel    <= ~(addr15 & m2_nxt);
      rsp_valid <= boundary && host_op && cpu_rw_out;
      if (boundary && host_op && cpu_rw_out) begin
        rsp_rdata <= cpu_data_in;
      end
      // Write data is driven through HIGH and held one clk into the next cycle.
      if (m2_nxt) begin
        cpu_data_oe <= ~cpu_rw_out;
      end else if (!boundary) begin
        cpu_data_oe <= 1'b0;
      end
      if (boundary) begin
        m2_cycle_count <= m2_cycle_count + 32'd1;
        host_op        <= req_valid;
        if (req_valid) begin
          addr15       <= req_addr[15];
          cpu_addr_out <= req_addr[14:0];
          cpu_rw_out   <= req_rw;
          if (!req_rw) begin
            cpu_data_out <= req_wdata;
          end
        end else begin
          addr15       <= IDLE_ADDR[15];
          cpu_addr_out <= IDLE_ADDR[14:0];
          cpu_rw_out   <= 1'b1;
        end
      end
    end
  end

  nes_irq_sync #(
    .STAGES    (IRQ_SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_irq_sync (
    .clk    (clk),
    .reset  (reset),
    .level  (irq),
    .synced (irq_synced)
  );

  assign irq_active = ~irq_synced;

endmodule

// File: tb/tb_nes_cpu_bus_initiator.sv
// Scenario bench for nes_cpu_bus_initiator with a read-data scoreboard queue.
module tb_nes_cpu_bus_initiator;

  localparam int LOW_CLKS  = 3;
  localparam int HIGH_CLKS = 3;
  localparam int PERIOD    = LOW_CLKS + HIGH_CLKS;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        m2;
  logic        romsel;
  logic        cpu_rw_out;
  logic [14:0] cpu_addr_out;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic [7:0]  cpu_data_in;
  logic        irq;
  logic        irq_active;
  logic [31:0] m2_cycle_count;

  logic [7:0]  cart_data;
  logic [7:0]  exp_q[$];
  int          ph;
  int          passed;
  int          total;

  nes_cpu_bus_initiator #(
    .M2_LOW_CLKS     (LOW_CLKS),
    .M2_HIGH_CLKS    (HIGH_CLKS),
    .IDLE_ADDR       (16'h0000),
    .IRQ_SYNC_STAGES (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rw         (req_rw),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .m2             (m2),
    .romsel         (romsel),
    .cpu_rw_out     (cpu_rw_out),
    .cpu_addr_out   (cpu_addr_out),
    .cpu_data_out   (cpu_data_out),
    .cpu_data_oe    (cpu_data_oe),
    .cpu_data_in    (cpu_data_in),
    .irq            (irq),
    .irq_active     (irq_active),
    .m2_cycle_count (m2_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cartridge only drives the bus while M2 is high on a read.
  assign cpu_data_in = (m2 && cpu_rw_out) ? cart_data : 8'hFF;

  // Reference bus-cycle position: 0..2 LOW, 3..5 HIGH, 5 = boundary.
  always @(posedge clk) begin
    if (reset) ph <= 0;
    else       ph <= (ph == PERIOD - 1) ? 0 : ph + 1;
  end

  task automatic issue(input bit rw, input logic [15:0] addr, input logic [7:0] wd, output bit ok);
    @(posedge clk); #1;
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) ok = 1'b1;
    end
    total++;
    if (!ok) $display("FAIL issue_ready addr=%h: no req_ready, required within 20 clks", addr);
    else passed++;
    total++;
    if (ok && ph != PERIOD - 1) $display("FAIL ready_on_boundary: ready at pos %0d, required %0d", ph, PERIOD - 1);
    else passed++;
    if (ok && rw) exp_q.push_back(cart_data);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_rw = 1'b1; req_addr = '0; req_wdata = '0;
    irq = 1'b1; cart_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (m2 !== 1'b0) $display("FAIL rst_m2: got %b expected 0", m2); else passed++;
    total++; if (romsel !== 1'b1) $display("FAIL rst_romsel: got %b expected 1", romsel); else passed++;
    total++; if (cpu_rw_out !== 1'b1) $display("FAIL rst_rw: got %b expected 1", cpu_rw_out); else passed++;
    total++; if (cpu_addr_out !== 15'h0) $display("FAIL rst_addr: got %h expected 0", cpu_addr_out); else passed++;
    total++; if (cpu_data_oe !== 1'b0) $display("FAIL rst_oe: got %b expected 0", cpu_data_oe); else passed++;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) $display("FAIL rst_handshake: rsp_valid=%b req_ready=%b expected 0/0", rsp_valid, req_ready); else passed++;
    total++; if (irq_active !== 1'b0) $display("FAIL rst_irq_active: got %b expected 0", irq_active); else passed++;
    total++; if (m2_cycle_count !== 32'd0) $display("FAIL rst_count: got %0d expected 0", m2_cycle_count); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int i = 0; i < 10 * PERIOD; i++) begin
      @(negedge clk);
      if (m2 !== ((i % PERIOD) >= LOW_CLKS)) bad++;
      if (romsel !== 1'b1 || cpu_rw_out !== 1'b1 || cpu_addr_out !== 15'h0) bad++;
      if (cpu_data_oe !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL idle_waveform: got %0d bad clks expected 0", bad); else passed++;
    @(negedge clk);
    total++; if (m2_cycle_count !== 32'd10) $display("FAIL idle_count: got %0d expected 10", m2_cycle_count); else passed++;
  endtask

  task automatic test_read();
    bit ok;
    int nrsp;
    logic [7:0] exp;
    cart_data = 8'hA5;
    issue(1'b1, 16'h8000, 8'h00, ok);
    @(posedge clk); #1; req_valid = 1'b0;
    nrsp = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k <= PERIOD) begin
        total++; if (m2 !== (k > LOW_CLKS)) $display("FAIL read_m2 k=%0d: got %b expected %b", k, m2, k > LOW_CLKS); else passed++;
        total++; if (romsel !== ~m2) $display("FAIL read_romsel k=%0d: got %b expected %b", k, romsel, ~m2); else passed++;
        total++; if (cpu_addr_out !== 15'h0 || cpu_rw_out !== 1'b1 || cpu_data_oe !== 1'b0)
          $display("FAIL read_bus k=%0d: addr=%h rw=%b oe=%b expected 0000/1/0", k, cpu_addr_out, cpu_rw_out, cpu_data_oe);
        else passed++;
      end
      if (rsp_valid === 1'b1) begin
        nrsp++;
        total++; if (k != PERIOD + 1) $display("FAIL read_latency: got %0d clks expected %0d", k, PERIOD + 1); else passed++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++; if (rsp_rdata !== exp) $display("FAIL read_data: got %h expected %h", rsp_rdata, exp); else passed++;
      end
    end
    total++; if (nrsp != 1) $display("FAIL read_rsp_count: got %0d expected 1", nrsp); else passed++;
  endtask

  task automatic test_write();
    bit ok;
    issue(1'b0, 16'h6001, 8'h3C, ok);
    @(posedge clk); #1; req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      total++; if (cpu_data_oe !== (k > LOW_CLKS && k <= PERIOD + 1))
        $display("FAIL write_oe k=%0d: got %b expected %b", k, cpu_data_oe, (k > LOW_CLKS && k <= PERIOD + 1));
      else passed++;
      total++; if (rsp_valid !== 1'b0) $display("FAIL write_no_rsp k=%0d: got %b expected 0", k, rsp_valid); else passed++;
      if (k <= PERIOD) begin
        total++; if (romsel !== 1'b1 || cpu_addr_out !== 15'h6001 || cpu_rw_out !== 1'b0 || cpu_data_out !== 8'h3C)
          $display("FAIL write_bus k=%0d: romsel=%b addr=%h rw=%b data=%h expected 1/6001/0/3c", k, romsel, cpu_addr_out, cpu_rw_out, cpu_data_out);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    bit got;
    issue(1'b0, 16'h8000, 8'h01, ok);
    @(posedge clk); #1; req_addr = 16'hC000; req_wdata = 8'h02;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (req_ready === 1'b1) got = 1'b1;
      else if (n == 1) begin
        total++; if (cpu_addr_out !== 15'h0 || cpu_rw_out !== 1'b0) $display("FAIL b2b_first_bus: addr=%h rw=%b expected 0000/0", cpu_addr_out, cpu_rw_out); else passed++;
      end else if (n == LOW_CLKS + 1) begin
        total++; if (romsel !== 1'b0 || cpu_data_oe !== 1'b1 || cpu_data_out !== 8'h01)
          $display("FAIL b2b_first_high: romsel=%b oe=%b data=%h expected 0/1/01", romsel, cpu_data_oe, cpu_data_out);
        else passed++;
      end
    end
    total++; if (n != PERIOD) $display("FAIL b2b_ready_spacing: got %0d clks expected %0d", n, PERIOD); else passed++;
    @(posedge clk); #1; req_valid = 1'b0;
    for (int k = 1; k <= PERIOD + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++; if (cpu_addr_out !== 15'h4000 || cpu_rw_out !== 1'b0 || cpu_data_oe !== 1'b1 || cpu_data_out !== 8'h02)
          $display("FAIL b2b_second_setup: addr=%h rw=%b oe=%b data=%h expected 4000/0/1/02", cpu_addr_out, cpu_rw_out, cpu_data_oe, cpu_data_out);
        else passed++;
      end else if (k == PERIOD) begin
        total++; if (romsel !== 1'b0 || cpu_data_oe !== 1'b1) $display("FAIL b2b_second_high: romsel=%b oe=%b expected 0/1", romsel, cpu_data_oe); else passed++;
      end else if (k == PERIOD + 2) begin
        total++; if (cpu_addr_out !== 15'h0 || cpu_rw_out !== 1'b1 || cpu_data_oe !== 1'b0)
          $display("FAIL b2b_idle_after: addr=%h rw=%b oe=%b expected 0000/1/0", cpu_addr_out, cpu_rw_out, cpu_data_oe);
        else passed++;
      end
    end
    total++; if (exp_q.size() != 0) $display("FAIL b2b_queue: got %0d pending expected 0", exp_q.size()); else passed++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    int bad;
    cart_data = 8'h5A;
    issue(1'b1, 16'hFFFC, 8'h00, ok);
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (PERIOD - 1) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h8000;
    @(negedge clk);
    total++; if (req_ready !== 1'b0) $display("FAIL reset_beats_valid: req_ready=%b expected 0", req_ready); else passed++;
    @(negedge clk);
    total++; if (m2 !== 1'b0 || romsel !== 1'b1 || cpu_rw_out !== 1'b1 || cpu_addr_out !== 15'h0)
      $display("FAIL midrst_bus: m2=%b romsel=%b rw=%b addr=%h expected 0/1/1/0000", m2, romsel, cpu_rw_out, cpu_addr_out);
    else passed++;
    total++; if (cpu_data_out !== 8'h00 || cpu_data_oe !== 1'b0) $display("FAIL midrst_data: data=%h oe=%b expected 00/0", cpu_data_out, cpu_data_oe); else passed++;
    total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) $display("FAIL midrst_rsp: valid=%b rdata=%h expected 0/00", rsp_valid, rsp_rdata); else passed++;
    total++; if (m2_cycle_count !== 32'd0) $display("FAIL midrst_count: got %0d expected 0", m2_cycle_count); else passed++;
    exp_q.delete();
    @(posedge clk); #1; reset = 1'b0; req_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < PERIOD + 1; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || cpu_addr_out !== 15'h0 || cpu_rw_out !== 1'b1) bad++;
      if (m2 !== ((i % PERIOD) >= LOW_CLKS)) bad++;
    end
    total++; if (bad != 0) $display("FAIL midrst_resume: got %0d bad clks expected 0", bad); else passed++;
    total++; if (m2_cycle_count !== 32'd1) $display("FAIL midrst_count_restart: got %0d expected 1", m2_cycle_count); else passed++;
  endtask

  task automatic test_irq();
    for (int t = 0; t < 10; t++) begin
      if (t == 0) begin @(posedge clk); #1; irq = 1'b0; end
      if (t == 5) begin @(posedge clk); #1; irq = 1'b1; end
      if (t != 0 && t != 5) @(posedge clk);
      @(negedge clk);
      total++; if (irq_active !== (t >= 2 && t <= 6))
        $display("FAIL irq_active t=%0d: got %b expected %b", t, irq_active, (t >= 2 && t <= 6));
      else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_idle();
    test_read();
    test_write();
    test_back_to_back();
    test_mid_reset();
    test_irq();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nes_cpu_bus_initiator.md
Name: nes_cpu_bus_initiator

Overview:
- Console-side CPU bus initiator that drives a cartridge exactly as a 2A03/Dendy CPU would.
- Generates free-running M2, /ROMSEL, R/W, A[14:0] and the data-bus direction.
- Executes single read/write requests from a host-side valid/ready port and returns read data.
- Used in the cartridge test fixture and in the flash programmer/dumper that talks to the multicart; it is the initiator for the bus the mapper top responds on.

Parameters:
- M2_LOW_CLKS, 3, clk cycles M2 is low per bus cycle (min 2).
- M2_HIGH_CLKS, 3, clk cycles M2 is high per bus cycle (min 2).
- IDLE_ADDR, 16'h0000, address presented, as a read, on bus cycles with no request.
- IRQ_SYNC_STAGES, 2, synchroniser depth on irq input.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  host request present.
- req_ready  output  1  one-clk pulse: request accepted this clk.
- req_rw  input  1  1 = read, 0 = write.
- req_addr  input  16  full CPU address.
- req_wdata  input  8  write data.
- rsp_valid  output  1  one-clk pulse: read data valid.
- rsp_rdata  output  8  captured read data.
- m2  output  1  M2 to cartridge.
- romsel  output  1  /ROMSEL, active low.
- cpu_rw_out  output  1  R/W to cartridge.
- cpu_addr_out  output  15  A[14:0] to cartridge.
- cpu_data_out  output  8  data driven to cartridge.
- cpu_data_oe  output  1  tri-state enable for cpu_data_out.
- cpu_data_in  input  8  data bus sampled from cartridge.
- irq  input  1  cartridge /IRQ, active low, asynchronous.
- irq_active  output  1  synchronised, inverted irq.
- m2_cycle_count  output  32  completed bus cycles since reset, wraps.

Behaviour:
- Reset values: m2=0, romsel=1, cpu_rw_out=1, cpu_addr_out=0, cpu_data_out=0, cpu_data_oe=0, req_ready=0, rsp_valid=0, rsp_rdata=0, irq_active=0, m2_cycle_count=0. Phase counter = 0 (first LOW clk).
- Phase FSM: LOW (M2_LOW_CLKS clks) -> HIGH (M2_HIGH_CLKS clks) -> LOW. It free-runs whenever reset is low; M2 never stops, because mapper logic counts M2 edges.
- Boundary clk = last HIGH clk.
- On the boundary clk, if req_valid=1: req_ready=1, request latched, and it executes in the next bus cycle. Otherwise the next cycle is an idle read of IDLE_ADDR.
- At most one request is accepted per bus cycle. req_ready is never asserted outside the boundary clk.
- Address/R/W: cpu_addr_out=addr[14:0] and cpu_rw_out are registered at the first LOW clk and held stable through the end of HIGH.
- romsel = ~(addr[15] & m2), registered, so it changes in the same clk as m2.
- m2 = 1 exactly during HIGH clks.
- Write: cpu_data_out=wdata from first LOW clk. cpu_data_oe=1 from first HIGH clk through first LOW clk of the following cycle (1-clk hold), then 0.
- Read: cpu_data_oe=0. cpu_data_in is sampled on the boundary clk into rsp_rdata. rsp_valid pulses on the following clk (first LOW clk of next cycle), for host reads only, never for idle reads.
- Latency: accept clk -> rsp_valid = M2_LOW_CLKS + M2_HIGH_CLKS + 1 clks.
- m2_cycle_count increments on every boundary clk and wraps 2^32-1 -> 0.
- irq: IRQ_SYNC_STAGES flop chain, irq_active = ~synchronised irq. No filtering.
- Mid-operation reset: the latched request is dropped with no rsp_valid. Outputs return to reset values next clk; the host must reissue.
- Simultaneous req_valid and reset: reset wins, no req_ready.
- Back-to-back requests with req_valid held: one accept per bus cycle. A write directly after a write overlaps oe hold with the new address setup; this is legal.

Decomposition:
- Shared package nes_bus_pkg: phase enum (PH_LOW, PH_HIGH); constants NES_ADDR_W=16, NES_DATA_W=8; parameter legality check (LOW/HIGH >= 2).
- One sub-module: nes_irq_sync (generic N-stage synchroniser). Everything else in the top.

Test Plan:
- Reset, no requests, 10 cycles (defaults) -> m2 period 6 clks, 50% duty; cpu_addr_out=0, rw=1, romsel=1 always; oe=0; m2_cycle_count=10; rsp_valid never.
- Read 16'h8000, cartridge returns 8'hA5 -> romsel low exactly during m2 high, addr=15'h0000, rw=1; rsp_valid once with rsp_rdata=8'hA5, 7 clks after req_ready.
- Write 16'h6001 data 8'h3C -> romsel stays 1, addr=15'h6001, rw=0; oe high for 4 clks (3 HIGH + 1 hold) with cpu_data_out=8'h3C; no rsp_valid.
- req_valid held for writes 16'h8000=8'h01 then 16'hC000=8'h02 -> exactly one req_ready per 6 clks; second write starts on the cycle directly after the first, with no idle cycle between.
- reset asserted mid-HIGH of a pending read -> next clk all outputs at reset values, no rsp_valid; after release the idle read of IDLE_ADDR resumes and m2_cycle_count restarts from 0.
- irq driven low for 5 clks, then high -> irq_active high for 5 clks, delayed 2 clks.
